// File: rtl/avalon_debounced_pio_in.sv
// Avalon-MM input PIO for push-buttons and switches.
// Each channel passes through a two-flop synchroniser and a debounce counter.
// Accepted transitions are captured into a write-1-to-clear edge register,
// and a maskable level interrupt is raised to the processor.
module avalon_debounced_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] edge_capture_next;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             irq_reg;
    logic             irq_next;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    // Two-flop synchroniser for the raw asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-channel debounce counter and accepted (stable) level.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [CW-1:0] cnt_reg;
        logic          stable_bit_reg;
        logic          accept;

        // The last counted cycle of a differing input is the acceptance edge.
        assign accept = (sync2_reg[gi] != stable_bit_reg) && (cnt_reg == CNT_LAST);
        assign stable_vec[gi] = stable_bit_reg;

        // Count consecutive differing cycles; any return to the stable value restarts.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_reg        <= '0;
                stable_bit_reg <= 1'b0;
            end else if (sync2_reg[gi] == stable_bit_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                stable_bit_reg <= sync2_reg[gi];
                cnt_reg        <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        // Qualify the accepted transition by direction.
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_set[gi] = accept & sync2_reg[gi];
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_set[gi] = accept & ~sync2_reg[gi];
        end else begin : g_any
            assign edge_set[gi] = accept;
        end
    end

    // Register-file next state: mask load, W1C with set priority, read mux, irq.
    always_comb begin
        mask_next         = mask_reg;
        edge_capture_next = edge_capture_reg;
        readdata_next     = '0;
        if (wr_en && address == 2'd2) begin
            mask_next = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edge_capture_next = edge_capture_reg & ~writedata[WIDTH-1:0];
        end
        edge_capture_next = edge_capture_next | edge_set;
        case (address)
            2'd0:    readdata_next[WIDTH-1:0] = stable_vec;
            2'd2:    readdata_next[WIDTH-1:0] = mask_reg;
            2'd3:    readdata_next[WIDTH-1:0] = edge_capture_reg;
            default: readdata_next = '0;
        endcase
        // Interrupt follows the registered capture/mask state one cycle later.
        irq_next = |(edge_capture_reg & mask_reg);
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg         <= '0;
            edge_capture_reg <= '0;
            readdata_reg     <= '0;
            irq_reg          <= 1'b0;
        end else begin
            mask_reg         <= mask_next;
            edge_capture_reg <= edge_capture_next;
            readdata_reg     <= readdata_next;
            irq_reg          <= irq_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule
